// File: rtl/ram_arb_pkg.sv
// Shared types for the two-host RAM arbiter: host indices and the
// registered response bookkeeping.
package ram_arb_pkg;

    localparam int NumHosts = 2;

    typedef enum logic {
        HostInstr = 1'b0,
        HostData  = 1'b1
    } host_e;

    typedef struct packed {
        logic  valid;
        host_e owner;
        logic  err;
    } rsp_t;

    // Unsigned distance from the window base; a wrap below base lands far above any span.
    function automatic logic [31:0] addrOffset(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant. The pointer names the host that wins the
// next contended cycle and moves only when a grant is actually issued.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    host_e r_prio;
    host_e w_prioNext;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio <= HostInstr;
        end else begin
            r_prio <= w_prioNext;
        end
    end

    // A grant is always a transfer, so the pointer hands priority to the other host.
    always_comb begin
        gnt_o      = 2'b00;
        w_prioNext = r_prio;
        if (!rst_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (r_prio == HostInstr) ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
            if (gnt_o[0]) begin
                w_prioNext = HostData;
            end else if (gnt_o[1]) begin
                w_prioNext = HostInstr;
            end
        end
    end

endmodule

// File: rtl/ram_1p_arb.sv
// Shares one single-port RAM between an instruction host and a data host;
// out-of-window accesses are answered locally with an error response.
module ram_1p_arb
    import ram_arb_pkg::*;
#(
    parameter int          Depth    = 128,
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         rst_i,

    input  logic [NumHosts-1:0]          h_req_i,
    input  logic [NumHosts-1:0]          h_we_i,
    input  logic [NumHosts-1:0][3:0]     h_be_i,
    input  logic [NumHosts-1:0][31:0]    h_addr_i,
    input  logic [NumHosts-1:0][31:0]    h_wdata_i,
    output logic [NumHosts-1:0]          h_gnt_o,
    output logic [NumHosts-1:0]          h_rvalid_o,
    output logic [NumHosts-1:0]          h_err_o,
    output logic [NumHosts-1:0][31:0]    h_rdata_o,

    output logic                         m_req_o,
    output logic                         m_we_o,
    output logic [3:0]                   m_be_o,
    output logic [31:0]                  m_addr_o,
    output logic [31:0]                  m_wdata_o,
    input  logic                         m_rvalid_i,
    input  logic [31:0]                  m_rdata_i
);

    localparam logic [31:0] SpanBytes = 32'(Depth * 4);

    logic [NumHosts-1:0] w_gnt;
    logic                w_any;
    host_e               w_win;
    logic [31:0]         w_offset;
    logic                w_inRange;
    rsp_t                r_rsp;

    rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (h_req_i),
        .gnt_o (w_gnt)
    );

    assign h_gnt_o = w_gnt;

    // Winner's request is steered to the RAM only when it falls inside the window.
    always_comb begin
        w_any     = |w_gnt;
        w_win     = w_gnt[1] ? HostData : HostInstr;
        w_offset  = addrOffset(h_addr_i[w_win], BaseAddr);
        w_inRange = (w_offset < SpanBytes);

        m_req_o   = w_any & w_inRange;
        m_we_o    = m_req_o & h_we_i[w_win];
        m_be_o    = m_req_o ? h_be_i[w_win]    : 4'h0;
        m_addr_o  = m_req_o ? w_offset         : 32'h0;
        m_wdata_o = m_req_o ? h_wdata_i[w_win] : 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp <= '{valid: 1'b0, owner: HostInstr, err: 1'b0};
        end else begin
            r_rsp.valid <= w_any;
            r_rsp.owner <= w_win;
            r_rsp.err   <= w_any & ~w_inRange;
        end
    end

    // Responses are masked while in reset so a RAM reply already in flight is dropped.
    always_comb begin
        h_rvalid_o = '0;
        h_err_o    = '0;
        h_rdata_o  = '0;
        if (!rst_i && r_rsp.valid) begin
            if (r_rsp.err) begin
                h_rvalid_o[r_rsp.owner] = 1'b1;
                h_err_o[r_rsp.owner]    = 1'b1;
            end else if (m_rvalid_i) begin
                h_rvalid_o[r_rsp.owner] = 1'b1;
                h_rdata_o[r_rsp.owner]  = m_rdata_i;
            end
        end
    end

    rspMatchesRam: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_rsp.valid && !r_rsp.err) |-> m_rvalid_i);

endmodule

// File: doc/ram_1p_arb.md
RAM_1P_ARB -- requirements
Module: ram_1p_arb

Interface
REQ-001 Parameter Depth, default 128, meaning number of 32-bit words in the attached ram_1p instance.
REQ-002 Parameter BaseAddr, default 32'h0000_0000, meaning byte address of RAM word 0; must be aligned to Depth*4.
REQ-003 Single clock domain; reset is synchronous and active-high.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 h_req_i  input  [2]  per-host request (index 0 = instruction host, 1 = data host).
REQ-007 h_we_i  input  [2]  per-host write enable.
REQ-008 h_be_i  input  [2][4]  per-host byte enables.
REQ-009 h_addr_i  input  [2][32]  per-host byte address.
REQ-010 h_wdata_i  input  [2][32]  per-host write data.
REQ-011 h_gnt_o  output  [2]  per-host grant, same cycle as the accepted request.
REQ-012 h_rvalid_o  output  [2]  per-host response valid.
REQ-013 h_err_o  output  [2]  per-host error flag, qualified by h_rvalid_o.
REQ-014 h_rdata_o  output  [2][32]  per-host read data, qualified by h_rvalid_o.
REQ-015 m_req_o / m_we_o / m_be_o[4] / m_addr_o[32] / m_wdata_o[32]  outputs  request to ram_1p.
REQ-016 m_rvalid_i  input  1, m_rdata_i  input  32  response from ram_1p.

Function
REQ-017 Transfer on host k occurs in a cycle where h_req_i[k] and h_gnt_o[k] are both 1; at most one h_gnt_o bit is 1 per cycle.
REQ-018 Grant is combinational from h_req_i and the priority state; a lone requester is granted in the same cycle.
REQ-019 Both requesting: grant goes to the host not granted most recently (round-robin); priority pointer updates only on a transfer.
REQ-020 In-range check: address in range when (h_addr_i - BaseAddr) < Depth*4, unsigned 32-bit subtraction (wrap-around below BaseAddr counts as out of range).
REQ-021 Granted in-range transfer: m_req_o=1, m_we_o/m_be_o/m_wdata_o forwarded from the winner, m_addr_o = h_addr_i - BaseAddr.
REQ-022 Granted out-of-range transfer: m_req_o=0 (no RAM access, no write); transfer still granted.
REQ-023 Response latency exactly 1 cycle after transfer for both in-range and out-of-range; arbiter sustains one transfer per cycle, back-to-back, including across hosts.
REQ-024 Response owner and error flag registered at transfer; next cycle h_rvalid_o[owner]=1, other bit 0.
REQ-025 In-range response: h_err_o[owner]=0, h_rdata_o[owner]=m_rdata_i; for writes rdata content is don't-care but rvalid still asserted.
REQ-026 Out-of-range response: h_err_o[owner]=1, h_rdata_o[owner]=32'h0.
REQ-027 Non-owner h_rdata_o and h_err_o are 0; all h_rdata_o are 0 when no response is pending.
REQ-028 In-range response h_rvalid_o derived from registered owner AND m_rvalid_i; mismatch (pending in-range, m_rvalid_i=0) is flagged by assertion.
REQ-029 No request queueing: an ungranted host holds its request; arbiter keeps no copy of it.

Reset
REQ-030 While rst_i=1: h_gnt_o=0, m_req_o=0, h_rvalid_o=0, h_err_o=0, h_rdata_o=0; m_we_o/m_be_o forced 0.
REQ-031 Reset sets the priority pointer so host 0 wins the first contended cycle.
REQ-032 Reset asserted one cycle after a transfer suppresses that response; no rvalid in the first cycle after reset deasserts.

Structure
REQ-033 Package ram_arb_pkg holds host index enum (HostInstr=0, HostData=1), NumHosts=2, and the response-state struct {valid, owner, err}.
REQ-034 One sub-module, rr_arb2: 2-input round-robin grant logic with pointer register, synchronous active-high reset.
REQ-035 Top level instantiates rr_arb2 only; ram_1p is instantiated by the integrating top, not inside this block.

Verification
REQ-036 Host 0 only, write 32'hDEADBEEF be=4'hF at BaseAddr+8, then read same -> gnt same cycle, m_addr_o=8, rvalid[0] next cycle, read data 32'hDEADBEEF, err=0.
REQ-037 Both hosts request reads continuously for 6 cycles after reset -> grants 0,1,0,1,0,1; each rvalid one cycle after its grant to matching host.
REQ-038 Host 1 read at BaseAddr+Depth*4 (=32'h200) and at BaseAddr-4 -> m_req_o=0, rvalid[1]=1, err[1]=1, rdata=0, RAM contents unchanged.
REQ-039 Host 1 byte write be=4'b0010 wdata=32'h0000AB00 over word 32'h11223344 -> subsequent read returns 32'h1122AB44.
REQ-040 Transfer granted, rst_i=1 next cycle -> no rvalid during or after reset; first post-reset contended cycle grants host 0.
